// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder: eight 8-bit registers, host write port, SPI read/write frames.
// Optional burst addressing is enabled by defining SPI_REG_RESPONDER_AUTOINC_EN.
`timescale 1ns/1ps
module spi_reg_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    input  logic        host_we,
    input  logic [2:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic [63:0] regs_out,
    output logic        spi_wr_pulse,
    output logic [2:0]  spi_wr_addr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CMD    = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_IGNORE = 2'd3;

    logic       cs_meta, cs_sync;
    logic       sclk_meta, sclk_sync, sclk_prev;
    logic       sdi_meta, sdi_sync;
    logic [1:0] sync_vld;
    logic       cs_armed;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [6:0] tx_sh;
    logic [2:0] addr;
    logic       rd;
    logic       load_pend;

    logic       sclk_rise, sclk_fall;
    logic       spi_commit;
    logic [7:0] spi_data;
    logic [7:0] rd_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            sdi_meta  <= 1'b0;
            sdi_sync  <= 1'b0;
            sync_vld  <= '0;
            cs_armed  <= 1'b0;
        end else begin
            cs_meta   <= spi_cs;
            cs_sync   <= cs_meta;
            sclk_meta <= spi_clk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            sdi_meta  <= spi_sdi;
            sdi_sync  <= sdi_meta;
            sync_vld  <= {sync_vld[0], 1'b1};
            // A real high chip select must be seen after reset before a frame can start.
            cs_armed  <= cs_armed | (sync_vld[1] & cs_sync);
        end
    end

    always_comb begin
        sclk_rise  = sclk_sync & ~sclk_prev;
        sclk_fall  = ~sclk_sync & sclk_prev;
        spi_data   = {shreg, sdi_sync};
        rd_byte    = regs_out[{addr, 3'b000} +: 8];
        spi_commit = (state == ST_DATA) & ~cs_sync & sclk_rise & (bit_cnt == 3'd7) & ~rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx_sh     <= '0;
            addr      <= '0;
            rd        <= 1'b0;
            load_pend <= 1'b0;
            spi_sdo   <= 1'b0;
        end else if (cs_sync) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            spi_sdo   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_armed) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        spi_sdo <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shreg   <= {shreg[5:0], sdi_sync};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state     <= ST_DATA;
                            rd        <= shreg[6];
                            addr      <= {shreg[1:0], sdi_sync};
                            load_pend <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        shreg   <= {shreg[5:0], sdi_sync};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SPI_REG_RESPONDER_AUTOINC_EN
                            addr      <= addr + 3'd1;
                            load_pend <= 1'b1;
`else
                            state   <= ST_IGNORE;
                            spi_sdo <= 1'b0;
`endif
                        end
                    end else if (sclk_fall) begin
                        // First fall of each byte loads the read data; write frames keep sdo low.
                        if (load_pend) begin
                            load_pend <= 1'b0;
                            tx_sh     <= rd ? rd_byte[6:0] : '0;
                            spi_sdo   <= rd & rd_byte[7];
                        end else begin
                            tx_sh   <= {tx_sh[5:0], 1'b0};
                            spi_sdo <= tx_sh[6];
                        end
                    end
                end
                ST_IGNORE: begin
                    spi_sdo <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // SPI commit is applied after the host write so it wins on an address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_out     <= '0;
            spi_wr_pulse <= 1'b0;
            spi_wr_addr  <= '0;
        end else begin
            spi_wr_pulse <= spi_commit;
            if (host_we) begin
                regs_out[{host_addr, 3'b000} +: 8] <= host_wdata;
            end
            if (spi_commit) begin
                regs_out[{addr, 3'b000} +: 8] <= spi_data;
                spi_wr_addr                   <= addr;
            end
        end
    end

endmodule

// File: doc/spi_reg_responder.md
SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (100 MHz).
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: spi_clk  in  1  SPI clock from master, asynchronous to clk.
REQ-004 SHALL have: spi_cs  in  1  chip select, active low, asynchronous.
REQ-005 SHALL have: spi_sdi  in  1  master-out data, asynchronous.
REQ-006 SHALL have: spi_sdo  out  1  slave-out data, registered.
REQ-007 SHALL have: host_we  in  1  local write strobe; host_addr  in  3; host_wdata  in  8.
REQ-008 SHALL have: regs_out  out  64  register file, reg N at bits [8N+7:8N].
REQ-009 SHALL have: spi_wr_pulse  out  1  one-cycle strobe on SPI register write; spi_wr_addr  out  3  address written.

Function
REQ-010 SHALL double-flop synchronise spi_clk, spi_cs and spi_sdi to clk before use; SCLK edges detected from the synchronised spi_clk.
REQ-011 SHALL support SPI mode 0, MSB first: sample spi_sdi on SCLK rise; update spi_sdo on SCLK fall; correct for SCLK period >= 8 clk cycles.
REQ-012 SHALL implement FSM IDLE, CMD, DATA, IGNORE; frame begins on synchronised spi_cs falling (IDLE->CMD, bit counter = 0).
REQ-013 Command byte SHALL be: bit7 = 1 read / 0 write, bits[6:3] ignored, bits[2:0] address.
REQ-014 After 8th CMD rise SHALL go to DATA; on the following SCLK fall, for read, load shift register with the addressed register and drive its MSB on spi_sdo.
REQ-015 In DATA each rise SHALL shift in spi_sdi; each fall SHALL shift out next bit of read data.
REQ-016 On 8th DATA rise of a write, SHALL update the addressed register within 2 clk and pulse spi_wr_pulse for exactly one cycle with spi_wr_addr.
REQ-017 spi_sdo SHALL be 0 in IDLE, CMD, IGNORE, during write frames and while spi_cs is high.
REQ-018 spi_cs rising in any state SHALL return FSM to IDLE within 3 clk; partial byte discarded, no register update, no pulse.
REQ-019 Host write (host_we=1) SHALL update register host_addr on the next clk edge.
REQ-020 Same-cycle SPI commit and host write to same address: SPI data SHALL win; different addresses: both committed.
REQ-021 SCLK edges while spi_cs high SHALL be ignored.

Reset
REQ-022 reset SHALL asynchronously clear regs_out to 64'h0, spi_sdo to 0, spi_wr_pulse to 0, spi_wr_addr to 0, FSM to IDLE, counters and shift registers to 0.
REQ-023 Synchroniser flops SHALL reset to idle bus values (spi_cs=1, spi_clk=0, spi_sdi=0); reset mid-frame aborts the frame, and a new frame requires a fresh spi_cs falling edge.

Configuration
REQ-024 Macro SPI_REG_RESPONDER_AUTOINC_EN defined: after each DATA byte, address SHALL increment modulo 8 (7 wraps to 0) and FSM stays in DATA for burst read/write.
REQ-025 Macro undefined: after first DATA byte FSM SHALL enter IGNORE until spi_cs high; further bytes neither write nor read (spi_sdo = 0).

Verification
REQ-026 Write frame cmd 8'h05, data 8'hA5 -> regs_out[47:40]=8'hA5, one spi_wr_pulse with spi_wr_addr=5.
REQ-027 Host writes reg 3 = 8'h3C, then SPI read cmd 8'h83 -> spi_sdo shifts 0,0,1,1,1,1,0,0 across the data byte.
REQ-028 Write frame cmd 8'h02, spi_cs raised after 4 data bits -> reg 2 unchanged, no pulse, next full frame works.
REQ-029 SPI write reg 1 = 8'h11 and host write reg 1 = 8'h22 committed in the same cycle -> reg 1 = 8'h11.
REQ-030 AUTOINC_EN defined: write cmd 8'h07 then 8'h01, 8'h02 -> reg 7=8'h01, reg 0=8'h02; undefined: reg 7=8'h01, reg 0 unchanged.
REQ-031 reset asserted mid-read frame -> spi_sdo=0, regs_out=0 immediately; subsequent frame after spi_cs toggle operates correctly.
